// File: rtl/din_sequence_checker_pkg.sv
// Shared definitions for the din pattern checker: FSM states and the default
// expected-pattern table also used by the generator side.
package din_sequence_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned DIN_WIDTH = 6;
    localparam int unsigned DIN_DEPTH = 5;

    // Index 0 sits in the LSBs: idx0=000000, idx1=011001, ..., idx4=001000.
    localparam logic [DIN_WIDTH*DIN_DEPTH-1:0] DIN_PAT_DEFAULT =
        {6'b001000, 6'b011000, 6'b011011, 6'b011001, 6'b000000};

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/din_sequence_checker_if.sv
// Control, data and status bundle of the din sequence checker.
interface din_sequence_checker_if
    import din_sequence_checker_pkg::*;
#(
    parameter int unsigned WIDTH = DIN_WIDTH,
    parameter int unsigned DEPTH = DIN_DEPTH,
    parameter int unsigned CNT_W = 4
) ();
    localparam int unsigned IDX_W = idx_width(DEPTH);

    logic             start;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic             err_pulse;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [IDX_W-1:0] first_err_idx;

    modport master (
        output start, din, din_valid,
        input  busy, done, pass, timeout, err_pulse, mismatch_cnt, first_err_idx
    );

    modport slave (
        input  start, din, din_valid,
        output busy, done, pass, timeout, err_pulse, mismatch_cnt, first_err_idx
    );

endinterface

// File: rtl/din_sequence_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module din_sequence_checker_sat_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/din_sequence_checker.sv
// Compares each din_valid strobe in order against EXP_PAT, counts mismatches,
// records the first failing index and aborts a run when the stream stalls.
module din_sequence_checker
    import din_sequence_checker_pkg::*;
#(
    parameter int unsigned                   WIDTH   = DIN_WIDTH,
    parameter int unsigned                   DEPTH   = DIN_DEPTH,
    parameter logic [WIDTH*DEPTH-1:0]        EXP_PAT = DIN_PAT_DEFAULT,
    parameter int unsigned                   TIMEOUT = 32,
    parameter int unsigned                   CNT_W   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    din_sequence_checker_if.slave    bus
);
    localparam int unsigned      IDX_W    = idx_width(DEPTH);
    localparam int unsigned      GAP_W    = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT - 1);

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic [GAP_W-1:0] r_gap, w_gap_next;
    logic             r_done, w_done_next;
    logic             r_pass, w_pass_next;
    logic             r_timeout, w_timeout_next;
    logic             r_err_pulse, w_err_pulse_next;
    logic [IDX_W-1:0] r_first_err, w_first_err_next;
    logic [WIDTH-1:0] w_exp;
    logic             w_mismatch;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic [CNT_W-1:0] w_cnt;

    assign w_exp      = EXP_PAT[r_idx*WIDTH +: WIDTH];
    assign w_mismatch = (bus.din != w_exp);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_gap_next       = r_gap;
        w_done_next      = r_done;
        w_pass_next      = r_pass;
        w_timeout_next   = r_timeout;
        w_err_pulse_next = 1'b0;
        w_first_err_next = r_first_err;
        w_cnt_clr        = 1'b0;
        w_cnt_inc        = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                // A strobe coincident with start is dropped: it lands outside RUN.
                if (bus.start) begin
                    w_state_next     = S_RUN;
                    w_idx_next       = '0;
                    w_gap_next       = '0;
                    w_done_next      = 1'b0;
                    w_pass_next      = 1'b0;
                    w_timeout_next   = 1'b0;
                    w_first_err_next = '0;
                    w_cnt_clr        = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.din_valid) begin
                    w_cnt_inc        = w_mismatch;
                    w_err_pulse_next = w_mismatch;
                    w_gap_next       = '0;
                    // Counter saturates but never returns to zero within a run.
                    if (w_mismatch && (w_cnt == '0)) begin
                        w_first_err_next = r_idx;
                    end
                    if (r_idx == LAST_IDX) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                        w_pass_next  = !w_mismatch && (w_cnt == '0);
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end else if (r_gap == GAP_MAX) begin
                    w_state_next   = S_DONE;
                    w_done_next    = 1'b1;
                    w_timeout_next = 1'b1;
                    w_pass_next    = 1'b0;
                end else begin
                    w_gap_next = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx       <= '0;
            r_gap       <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_pulse <= 1'b0;
            r_first_err <= '0;
        end else begin
            r_idx       <= w_idx_next;
            r_gap       <= w_gap_next;
            r_done      <= w_done_next;
            r_pass      <= w_pass_next;
            r_timeout   <= w_timeout_next;
            r_err_pulse <= w_err_pulse_next;
            r_first_err <= w_first_err_next;
        end
    end

    din_sequence_checker_sat_counter #(
        .CNT_W (CNT_W)
    ) u_mismatch_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_cnt (w_cnt)
    );

    assign bus.busy          = (r_state == S_RUN);
    assign bus.done          = r_done;
    assign bus.pass          = r_pass;
    assign bus.timeout       = r_timeout;
    assign bus.err_pulse     = r_err_pulse;
    assign bus.mismatch_cnt  = w_cnt;
    assign bus.first_err_idx = r_first_err;

endmodule

// File: tb/tb_din_sequence_checker.sv
// Self-checking bench for din_sequence_checker: vector table plus hand-written corner sequences.
module tb_din_sequence_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    din_sequence_checker_if #(.WIDTH(6), .DEPTH(5), .CNT_W(4)) bus ();
    din_sequence_checker_if #(.WIDTH(6), .DEPTH(5), .CNT_W(2)) bus2 ();

    din_sequence_checker #(.CNT_W(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    din_sequence_checker #(.CNT_W(2)) dut_sat (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2)
    );

    logic [5:0] exp_tab [5];

    typedef struct {
        int   due;
        logic err;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [4:0] bad_mask;
        int         spacing;
        logic [3:0] exp_cnt;
        logic [2:0] exp_first;
        logic       exp_pass;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // err_pulse scoreboard: each driven strobe queues the pulse expected after its edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            sb_t it;
            it = sb_q.pop_front();
            chk("err_pulse", {31'd0, bus.err_pulse}, {31'd0, it.err});
        end else if (bus.err_pulse) begin
            chk("err_pulse_spurious", {31'd0, bus.err_pulse}, 32'd0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        bus.din_valid = 1'b0;
        bus2.start = 1'b0;
        bus2.din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Drive one strobe; hold=1 leaves din_valid high for a back-to-back follower.
    task automatic strobe(input logic [5:0] d, input logic exp_err, input bit hold);
        sb_t it;
        @(negedge clk);
        bus.din = d;
        bus.din_valid = 1'b1;
        it.due = cyc + 1;
        it.err = exp_err;
        sb_q.push_back(it);
        if (!hold) begin
            @(negedge clk);
            bus.din_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_tab = '{6'b000000, 6'b011001, 6'b011011, 6'b011000, 6'b001000};
        vecs[0] = '{bad_mask: 5'b00000, spacing: 9, exp_cnt: 4'd0, exp_first: 3'd0, exp_pass: 1'b1};
        vecs[1] = '{bad_mask: 5'b00100, spacing: 9, exp_cnt: 4'd1, exp_first: 3'd2, exp_pass: 1'b0};
        vecs[2] = '{bad_mask: 5'b00000, spacing: 0, exp_cnt: 4'd0, exp_first: 3'd0, exp_pass: 1'b1};
        vecs[3] = '{bad_mask: 5'b10010, spacing: 2, exp_cnt: 4'd2, exp_first: 3'd1, exp_pass: 1'b0};
        vecs[4] = '{bad_mask: 5'b10000, spacing: 0, exp_cnt: 4'd1, exp_first: 3'd4, exp_pass: 1'b0};
        vecs[5] = '{bad_mask: 5'b11111, spacing: 0, exp_cnt: 4'd5, exp_first: 3'd0, exp_pass: 1'b0};

        bus.start = 1'b0;  bus.din = '0;  bus.din_valid = 1'b0;
        bus2.start = 1'b0; bus2.din = '0; bus2.din_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_cnt", {28'd0, bus.mismatch_cnt}, 32'd0);

        // Table-driven runs; each after the first restarts from DONE.
        for (int v = 0; v < 6; v++) begin
            do_start();
            chk($sformatf("v%0d_busy_start", v), {31'd0, bus.busy}, 32'd1);
            chk($sformatf("v%0d_cleared", v), {27'd0, bus.done, bus.mismatch_cnt}, 32'd0);
            for (int k = 0; k < 5; k++) begin
                logic [5:0] d;
                logic       bad;
                bad = vecs[v].bad_mask[k];
                d = exp_tab[k] ^ {5'd0, bad};
                if (k == 4) begin
                    strobe(d, bad, 1'b1);
                end else if (vecs[v].spacing == 0) begin
                    strobe(d, bad, 1'b1);
                end else begin
                    strobe(d, bad, 1'b0);
                    repeat (vecs[v].spacing - 1) @(negedge clk);
                end
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done", v), {31'd0, bus.done}, 32'd1);
            chk($sformatf("v%0d_busy", v), {31'd0, bus.busy}, 32'd0);
            chk($sformatf("v%0d_pass", v), {31'd0, bus.pass}, {31'd0, vecs[v].exp_pass});
            chk($sformatf("v%0d_timeout", v), {31'd0, bus.timeout}, 32'd0);
            chk($sformatf("v%0d_cnt", v), {28'd0, bus.mismatch_cnt}, {28'd0, vecs[v].exp_cnt});
            chk($sformatf("v%0d_first", v), {29'd0, bus.first_err_idx}, {29'd0, vecs[v].exp_first});
            @(negedge clk);
            bus.din_valid = 1'b0;
        end

        // Stalled stream: timeout exactly 32 cycles after the third strobe.
        do_reset();
        do_start();
        for (int k = 0; k < 3; k++) strobe(exp_tab[k], 1'b0, 1'b0);
        repeat (31) @(posedge clk);
        #1;
        chk("to_not_yet", {30'd0, bus.done, bus.busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("to_done", {31'd0, bus.done}, 32'd1);
        chk("to_timeout", {31'd0, bus.timeout}, 32'd1);
        chk("to_pass", {31'd0, bus.pass}, 32'd0);
        chk("to_cnt", {28'd0, bus.mismatch_cnt}, 32'd0);
        chk("to_busy", {31'd0, bus.busy}, 32'd0);

        // Reset mid-run clears everything; later strobes are ignored.
        do_reset();
        do_start();
        strobe(exp_tab[0], 1'b0, 1'b0);
        strobe(exp_tab[1] ^ 6'b000010, 1'b1, 1'b0);
        do_reset();
        chk("mr_busy", {31'd0, bus.busy}, 32'd0);
        chk("mr_status", {28'd0, bus.done, bus.pass, bus.timeout, bus.err_pulse}, 32'd0);
        chk("mr_cnt_first", {25'd0, bus.mismatch_cnt, bus.first_err_idx}, 32'd0);
        for (int k = 2; k < 5; k++) strobe(exp_tab[k] ^ 6'b100000, 1'b0, 1'b0);
        chk("mr_ignored", {27'd0, bus.done, bus.mismatch_cnt}, 32'd0);

        // Strobe with start is dropped; start during RUN is ignored; restart from DONE.
        do_reset();
        begin
            sb_t it;
            @(negedge clk);
            bus.start = 1'b1;
            bus.din = ~exp_tab[0];
            bus.din_valid = 1'b1;
            it.due = cyc + 1;
            it.err = 1'b0;
            sb_q.push_back(it);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.din_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            strobe(~exp_tab[k], 1'b1, 1'b1);
            bus.start = (k == 2);
        end
        @(posedge clk);
        #1;
        chk("sw_done", {31'd0, bus.done}, 32'd1);
        chk("sw_cnt", {28'd0, bus.mismatch_cnt}, 32'd5);
        chk("sw_first", {29'd0, bus.first_err_idx}, 32'd0);
        chk("sw_pass", {31'd0, bus.pass}, 32'd0);
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.start = 1'b0;
        do_start();
        chk("sw_restart", {27'd0, bus.done, bus.mismatch_cnt}, 32'd0);
        chk("sw_restart_busy", {31'd0, bus.busy}, 32'd1);

        // Narrow counter saturates at 3.
        do_reset();
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus2.din = ~exp_tab[k];
            bus2.din_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("sat_cnt", {30'd0, bus2.mismatch_cnt}, 32'd3);
        chk("sat_done", {31'd0, bus2.done}, 32'd1);
        chk("sat_pass", {31'd0, bus2.pass}, 32'd0);
        @(negedge clk);
        bus2.din_valid = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
